// File: rtl/lane_traffic_ctrl_pkg.sv
// Game-wide constants for the lane traffic block: display width, default
// lane periods and start positions, and the lane direction encoding.
package lane_traffic_ctrl_pkg;

    localparam int unsigned NUM_LANES_DEF  = 4;
    localparam int unsigned X_WIDTH_DEF    = 10;
    localparam int unsigned CNT_WIDTH_DEF  = 24;
    localparam int unsigned LEVEL_WIDTH    = 2;
    localparam int unsigned GAME_H_DISPLAY = 640;

    // Flattened per-lane defaults, lane 0 in the LSBs.
    localparam logic [NUM_LANES_DEF*CNT_WIDTH_DEF-1:0] DEF_LANE_PERIOD = {4{24'd250000}};
    localparam logic [NUM_LANES_DEF*X_WIDTH_DEF-1:0]   DEF_INIT_X      =
        {10'd480, 10'd320, 10'd160, 10'd0};

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_e;

endpackage

// File: rtl/lane_traffic_ctrl_if.sv
// Control/position bundle between game-state logic (master) and the lane
// traffic block (slave).
//   i_run      1 = lanes advance
//   i_restart  single-cycle reload of start positions
//   i_level    difficulty level 0..3
//   i_dir      per-lane direction, 0 = +x, 1 = -x
//   o_car_x    flattened car positions, lane 0 in LSBs
//   o_step     per-lane step pulse
//   o_wrap     per-lane wrap pulse
interface lane_traffic_ctrl_if
    import lane_traffic_ctrl_pkg::*;
#(
    parameter int unsigned NUM_LANES = NUM_LANES_DEF,
    parameter int unsigned X_WIDTH   = X_WIDTH_DEF
);
    logic                           i_run;
    logic                           i_restart;
    logic [LEVEL_WIDTH-1:0]         i_level;
    logic [NUM_LANES-1:0]           i_dir;
    logic [NUM_LANES*X_WIDTH-1:0]   o_car_x;
    logic [NUM_LANES-1:0]           o_step;
    logic [NUM_LANES-1:0]           o_wrap;

    modport master (
        output i_run, i_restart, i_level, i_dir,
        input  o_car_x, o_step, o_wrap
    );

    modport slave (
        input  i_run, i_restart, i_level, i_dir,
        output o_car_x, o_step, o_wrap
    );
endinterface

// File: rtl/lane_traffic_ctrl_lane_mover.sv
// One lane: level-scaled step prescaler plus wrapping position register.
//   CLK, RST_N  clock, synchronous active-low reset
//   run         advance enable
//   restart     reload INIT, clear count
//   level       difficulty, divides PERIOD by 2**level
//   dir         0 = +x, 1 = -x, used on step cycles
//   x           registered position
//   step, wrap  registered single-cycle pulses
module lane_mover
    import lane_traffic_ctrl_pkg::*;
#(
    parameter int unsigned          X_WIDTH   = X_WIDTH_DEF,
    parameter int unsigned          H_DISPLAY = GAME_H_DISPLAY,
    parameter int unsigned          CNT_WIDTH = CNT_WIDTH_DEF,
    parameter logic [CNT_WIDTH-1:0] PERIOD    = CNT_WIDTH'(DEF_LANE_PERIOD[CNT_WIDTH_DEF-1:0]),
    parameter logic [X_WIDTH-1:0]   INIT      = '0
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   run,
    input  logic                   restart,
    input  logic [LEVEL_WIDTH-1:0] level,
    input  logic                   dir,
    output logic [X_WIDTH-1:0]     x,
    output logic                   step,
    output logic                   wrap
);

    localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(H_DISPLAY - 1);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] period_sh;
    logic [CNT_WIDTH-1:0] eff_m1;
    logic [X_WIDTH-1:0]   x_q, x_d;
    logic                 step_q, step_d;
    logic                 wrap_q, wrap_d;
    logic                 at_edge;
    logic                 go_left;

    // Terminal count: max(PERIOD >> level, 1) - 1.
    always_comb begin
        period_sh = PERIOD >> level;
        eff_m1    = (period_sh == '0) ? '0 : period_sh - CNT_WIDTH'(1);
    end

    // Next state. '>=' lets a level increase that shrinks the period below
    // the running count step on the very next enabled cycle.
    always_comb begin
        cnt_d   = cnt_q;
        x_d     = x_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        go_left = (dir_e'(dir) == DIR_LEFT);
        at_edge = go_left ? (x_q == '0) : (x_q == X_LAST);
        if (restart) begin
            cnt_d = '0;
            x_d   = INIT;
        end else if (run) begin
            if (cnt_q >= eff_m1) begin
                cnt_d  = '0;
                step_d = 1'b1;
                wrap_d = at_edge;
                if (go_left) x_d = at_edge ? X_LAST : x_q - X_WIDTH'(1);
                else         x_d = at_edge ? '0     : x_q + X_WIDTH'(1);
            end else begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt_q  <= '0;
            x_q    <= INIT;
            step_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            x_q    <= x_d;
            step_q <= step_d;
            wrap_q <= wrap_d;
        end
    end

    // An out-of-range INIT shows up here right after reset.
    always_ff @(posedge CLK) begin
        if (RST_N) begin
            assert (x_q <= X_LAST)
                else $error("lane_mover: position %0d outside display (check INIT)", x_q);
        end
    end

    assign x    = x_q;
    assign step = step_q;
    assign wrap = wrap_q;

endmodule

// File: rtl/lane_traffic_ctrl.sv
// Car-position generator: NUM_LANES independent lane_mover instances with
// outputs flattened onto the bus (lane 0 in LSBs).
//   CLK, RST_N  clock, synchronous active-low reset
//   bus         slave side of lane_traffic_ctrl_if (run/restart/level/dir in,
//               car_x/step/wrap out)
module lane_traffic_ctrl
    import lane_traffic_ctrl_pkg::*;
#(
    parameter int unsigned                    NUM_LANES   = NUM_LANES_DEF,
    parameter int unsigned                    X_WIDTH     = X_WIDTH_DEF,
    parameter int unsigned                    H_DISPLAY   = GAME_H_DISPLAY,
    parameter int unsigned                    CNT_WIDTH   = CNT_WIDTH_DEF,
    parameter logic [NUM_LANES*CNT_WIDTH-1:0] LANE_PERIOD = DEF_LANE_PERIOD,
    parameter logic [NUM_LANES*X_WIDTH-1:0]   INIT_X      = DEF_INIT_X
) (
    input  logic               CLK,
    input  logic               RST_N,
    lane_traffic_ctrl_if.slave bus
);

    logic [NUM_LANES*X_WIDTH-1:0] car_x;
    logic [NUM_LANES-1:0]         step;
    logic [NUM_LANES-1:0]         wrap;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lane_mover #(
            .X_WIDTH   (X_WIDTH),
            .H_DISPLAY (H_DISPLAY),
            .CNT_WIDTH (CNT_WIDTH),
            .PERIOD    (LANE_PERIOD[i*CNT_WIDTH +: CNT_WIDTH]),
            .INIT      (INIT_X[i*X_WIDTH +: X_WIDTH])
        ) u_lane (
            .CLK     (CLK),
            .RST_N   (RST_N),
            .run     (bus.i_run),
            .restart (bus.i_restart),
            .level   (bus.i_level),
            .dir     (bus.i_dir[i]),
            .x       (car_x[i*X_WIDTH +: X_WIDTH]),
            .step    (step[i]),
            .wrap    (wrap[i])
        );
    end

    assign bus.o_car_x = car_x;
    assign bus.o_step  = step;
    assign bus.o_wrap  = wrap;

endmodule
